// File: rtl/pipe_buffer.sv
// Elastic FIFO buffer between two pipeline stages: registered up_ready, synchronous
// flush, optional empty-bypass path and a saturating back-pressure counter.
module pipe_buffer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2,
    parameter int PASSTHRU = 0,
    parameter int STALL_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         up_valid,
    output logic                         up_ready,
    input  logic [WIDTH-1:0]             up_data,
    output logic                         down_valid,
    input  logic                         down_ready,
    output logic [WIDTH-1:0]             down_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [STALL_W-1:0]           stall_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic empty;
    logic bypass_offer;
    logic bypass;
    logic push;
    logic pop;
    logic push_st;
    logic pop_st;

    assign empty = (count_q == '0);

    // up_ready looks only at local state so the ready chain is cut at every buffer.
    assign up_ready     = !reset && !flush && (count_q != FULL);
    assign bypass_offer = (PASSTHRU != 0) && empty && up_valid && !flush && !reset;
    assign down_valid   = (!empty && !flush && !reset) || bypass_offer;
    assign down_data    = ((PASSTHRU != 0) && empty) ? up_data : mem_q[rd_ptr_q];

    assign push    = up_valid && up_ready;
    assign pop     = down_valid && down_ready;
    assign bypass  = bypass_offer && down_ready;
    assign push_st = push && !bypass;
    assign pop_st  = pop && !empty;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_st) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_st)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_st, pop_st})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (down_valid && !down_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // NOTE: storage has no reset; count gates every read so stale contents are never seen.
    always_ff @(posedge clk) begin
        if (push_st) begin
            mem_q[wr_ptr_q] <= up_data;
        end
    end

    assign count       = count_q;
    assign stall_count = stall_q;

endmodule

// File: doc/pipe_buffer.md
Name: pipe_buffer

Overview:
- Parametrised elastic buffer placed between any two pipeline stages (fetcher→decoder, decoder→executor, executor→accessor, accessor→writeback). It replaces ad-hoc per-stage valid/ready latching.
- Generalises the single-entry stage handshake to WIDTH bits and DEPTH entries.
- Adds a synchronous flush for redirects and an optional empty-bypass mode.
- Adds a saturating back-pressure counter for performance analysis.

Parameters:
- WIDTH, 32: payload width in bits; must be ≥1.
- DEPTH, 2: number of storage entries; must be a power of 2 and ≥2.
- PASSTHRU, 0: 1 allows a same-cycle combinational path from up to down while the buffer is empty; 0 always adds one cycle of latency.
- STALL_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all entries.
- up_valid  in  1  upstream offers up_data.
- up_ready  out  1  buffer accepts up_data this cycle.
- up_data  in  WIDTH  upstream payload.
- down_valid  out  1  buffer offers down_data.
- down_ready  in  1  downstream accepts this cycle.
- down_data  out  WIDTH  head payload.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- stall_count  out  STALL_W  cycles with down_valid=1 and down_ready=0.

Behaviour:
- State:
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count register.
  - DEPTH×WIDTH storage array; storage is not reset.
- Reset (asynchronous, while reset=1):
  - wr_ptr=0, rd_ptr=0, count=0, stall_count=0.
  - up_ready=0 and down_valid=0 while reset is high.
  - down_data is don't-care.
- Transfers:
  - push = up_valid & up_ready.
  - pop = down_valid & down_ready.
- up_ready = !reset & !flush & (count != DEPTH).
  - up_ready depends only on state, flush and reset, never on down_ready. This breaks the ready chain.
  - Consequence: when full, a same-cycle pop does not open a slot. up_ready rises the cycle after the pop.
- down_valid:
  - (count != 0) & !flush & !reset.
  - If PASSTHRU=1, additionally true when count == 0 and up_valid=1 and flush=0.
- down_data:
  - mem[rd_ptr] when count != 0.
  - up_data when PASSTHRU=1 and count == 0.
- Bypass case (PASSTHRU=1, count=0, up_valid=1, down_ready=1):
  - The word is delivered the same cycle and is not stored.
  - Pointers and count are unchanged.
- Normal update (flush=0):
  - On push (not bypassed): mem[wr_ptr] ← up_data; wr_ptr++.
  - On pop from storage: rd_ptr++.
  - count += push_stored − pop_stored. A simultaneous push and pop leaves count unchanged.
- Flush (flush=1):
  - Next edge: wr_ptr=0, rd_ptr=0, count=0.
  - Any concurrent up_valid is dropped (up_ready=0). No data is presented downstream that cycle.
  - stall_count is not cleared.
- Latency: data accepted at edge N appears on down_data after edge N (1 cycle) when the buffer was empty and PASSTHRU=0. The bypass case has 0 cycles.
- Throughput: 1 word/cycle sustained whenever count < DEPTH.
- Ordering: strict FIFO; no reorder or duplication.
- Wrap: pointers roll DEPTH−1 → 0 with no bubble.
- stall_count:
  - Increments each edge where down_valid & !down_ready.
  - Saturates at 2^STALL_W−1; never wraps.
  - Cleared only by reset.
- Protocol requirements:
  - Upstream must hold up_valid and up_data stable until up_ready.
  - The buffer holds down_valid and down_data stable until down_ready or flush.
- Reset asserted mid-transfer: all entries are lost; no partial word is emitted after reset deasserts.

Test Plan:
- Fill/drain: WIDTH=32, DEPTH=4, PASSTHRU=0, down_ready=0; push 0x11, 0x22, 0x33, 0x44.
  - up_ready=0 after the 4th push; count=4; stall_count increments each cycle.
  - With down_ready=1: outputs 0x11, 0x22, 0x33, 0x44 in order; count returns to 0.
- Full boundary: with count=4, hold up_valid=1 (data 0x55) and assert down_ready for 1 cycle.
  - That cycle: up_ready stays 0 and 0x11 pops.
  - Next cycle: up_ready=1 and 0x55 is accepted; it appears after 0x44.
- Streaming wrap: up_valid=down_ready=1 for 20 cycles with an incrementing payload 0..19.
  - Every value appears exactly once, in order.
  - count is constant at 1; pointers wrap 5 times.
- Flush: count=3; assert flush together with up_valid (data 0xAA).
  - Next cycle: count=0, down_valid=0.
  - 0xAA is never emitted; stall_count is retained.
- Bypass (PASSTHRU=1): empty buffer, up_valid=1 with up_data=0xDEADBEEF, down_ready=1.
  - Same cycle: down_valid=1, down_data=0xDEADBEEF.
  - count stays 0.
- Async reset mid-run: count=2, stall_count=7; pulse reset between clock edges.
  - Immediately: count=0, stall_count=0, down_valid=0, up_ready=0.
  - First edge after release: up_ready=1.
